// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN activation path: index width, index slot
// positions and the loader state encoding.
package dnn_pkg;

  // Every activation index is carried as a zero-extended 16-bit value.
  localparam int unsigned IdxWidth = 16;

  // Slot positions inside the three-entry activation index.
  localparam int unsigned IdxX     = 0;
  localparam int unsigned IdxY     = 1;
  localparam int unsigned IdxEntry = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } load_state_e;

endpackage

// File: rtl/act_index_counter.sv
// Raster-order x/y/entry counter: x runs fastest, then y, then entry.
// 'last' flags the final position of the whole tensor.
module act_index_counter import dnn_pkg::*; #(
  parameter int unsigned NUM_INPUTS = 1,
  parameter int unsigned INPUT_DIM  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                step,
  output logic [IdxWidth-1:0] x,
  output logic [IdxWidth-1:0] y,
  output logic [IdxWidth-1:0] entry,
  output logic                last
);

  localparam logic [IdxWidth-1:0] DimMax   = IdxWidth'(INPUT_DIM - 1);
  localparam logic [IdxWidth-1:0] EntryMax = IdxWidth'(NUM_INPUTS - 1);
  localparam logic [IdxWidth-1:0] One      = IdxWidth'(1);

  logic [IdxWidth-1:0] x_q, x_d;
  logic [IdxWidth-1:0] y_q, y_d;
  logic [IdxWidth-1:0] entry_q, entry_d;

  logic x_at_max, y_at_max, entry_at_max;

  assign x_at_max     = (x_q == DimMax);
  assign y_at_max     = (y_q == DimMax);
  assign entry_at_max = (entry_q == EntryMax);

  // Next position: clear wins over step; wraps cascade x -> y -> entry.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    entry_d = entry_q;
    if (clear) begin
      x_d     = '0;
      y_d     = '0;
      entry_d = '0;
    end else if (step) begin
      if (x_at_max) begin
        x_d = '0;
        if (y_at_max) begin
          y_d     = '0;
          entry_d = entry_at_max ? '0 : entry_q + One;
        end else begin
          y_d = y_q + One;
        end
      end else begin
        x_d = x_q + One;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      entry_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      entry_q <= entry_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign entry = entry_q;
  assign last  = x_at_max && y_at_max && entry_at_max;

endmodule

// File: rtl/act_loader.sv
// Activation loader: streams NUM_INPUTS*INPUT_DIM*INPUT_DIM words from an
// upstream valid/ready source into the conv-layer activation memory in raster
// order. Optional protocol checker enabled by macro ACT_LOADER_CHECK_EN
// (adds sticky 'err' output).
module act_loader import dnn_pkg::*; #(
  parameter int unsigned NUM_INPUTS = 1,
  parameter int unsigned INPUT_DIM  = 5,
  parameter int unsigned DATA_SIZE  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DATA_SIZE-1:0]     in_data,
  output logic                     in_ready,
  output logic                     want_write,
  output logic [DATA_SIZE-1:0]     write_data,
  output logic [2:0][IdxWidth-1:0] in_index_act,
  output logic                     busy,
`ifdef ACT_LOADER_CHECK_EN
  output logic                     done,
  output logic                     err
`else
  output logic                     done
`endif
);

  load_state_e state_q, state_d;

  logic                     accept;
  logic                     cnt_clear;
  logic                     cnt_last;
  logic [IdxWidth-1:0]      cnt_x, cnt_y, cnt_entry;
  logic                     want_write_q;
  logic [DATA_SIZE-1:0]     write_data_q;
  logic [2:0][IdxWidth-1:0] index_q;

  assign accept    = in_valid && (state_q == StLoad);
  // Counters restart only on the IDLE -> LOAD transition.
  assign cnt_clear = (state_q == StIdle) && start;

  act_index_counter #(
    .NUM_INPUTS (NUM_INPUTS),
    .INPUT_DIM  (INPUT_DIM)
  ) u_index_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .step  (accept),
    .x     (cnt_x),
    .y     (cnt_y),
    .entry (cnt_entry),
    .last  (cnt_last)
  );

  // Next-state logic: start only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (accept && cnt_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Write port: data/index only update on an accepted word, so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      want_write_q <= 1'b0;
      write_data_q <= '0;
      index_q      <= '0;
    end else begin
      want_write_q <= accept;
      if (accept) begin
        write_data_q      <= in_data;
        index_q[IdxX]     <= cnt_x;
        index_q[IdxY]     <= cnt_y;
        index_q[IdxEntry] <= cnt_entry;
      end
    end
  end

  assign in_ready     = (state_q == StLoad);
  assign busy         = (state_q == StLoad);
  assign done         = (state_q == StDone);
  assign want_write   = want_write_q;
  assign write_data   = write_data_q;
  assign in_index_act = index_q;

`ifdef ACT_LOADER_CHECK_EN
  logic err_q;

  // Sticky protocol error: data offered outside LOAD or start outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((in_valid && (state_q != StLoad)) || (start && (state_q != StIdle))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_act_loader.sv
// Self-checking bench for act_loader. Two instances (1 and 2 feature maps,
// 5x5) share clock/reset; 'sel' routes stimulus to one and observes it.
module tb_act_loader;

  localparam int D = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;
  logic [63:0] in_data = '0;

  logic start1, start2, valid1, valid2;
  assign start1 = start & ~sel;
  assign valid1 = in_valid & ~sel;
  assign start2 = start & sel;
  assign valid2 = in_valid & sel;

  logic            rdy1, ww1, busy1, done1, err1;
  logic [63:0]     wd1;
  logic [2:0][15:0] idx1;
  logic            rdy2, ww2, busy2, done2, err2;
  logic [63:0]     wd2;
  logic [2:0][15:0] idx2;

  act_loader #(.NUM_INPUTS(1), .INPUT_DIM(D), .DATA_SIZE(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(valid1), .in_data(in_data),
    .in_ready(rdy1), .want_write(ww1), .write_data(wd1), .in_index_act(idx1),
    .busy(busy1),
`ifdef ACT_LOADER_CHECK_EN
    .done(done1), .err(err1)
`else
    .done(done1)
`endif
  );

  act_loader #(.NUM_INPUTS(2), .INPUT_DIM(D), .DATA_SIZE(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(valid2), .in_data(in_data),
    .in_ready(rdy2), .want_write(ww2), .write_data(wd2), .in_index_act(idx2),
    .busy(busy2),
`ifdef ACT_LOADER_CHECK_EN
    .done(done2), .err(err2)
`else
    .done(done2)
`endif
  );

`ifndef ACT_LOADER_CHECK_EN
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  always #5 clk = ~clk;

  // Observed bundle: {ready, busy, done, want_write, err, data[63:0], idx[47:0]}.
  logic [116:0] obs;
  logic         obs_ww;
  logic [63:0]  obs_data;
  logic [47:0]  obs_idx;
  assign obs = sel ? {rdy2, busy2, done2, ww2, err2, wd2, idx2}
                   : {rdy1, busy1, done1, ww1, err1, wd1, idx1};
  assign obs_ww   = obs[113];
  assign obs_data = obs[111:48];
  assign obs_idx  = obs[47:0];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 loading, 2 done; m_k words accepted so far.
  int          m_ph, m_k, m_total;
  bit          m_ww, m_err;
  logic [63:0] m_data;
  logic [47:0] m_idx;
  logic [47:0] first_idx, seen26;

  function automatic logic [47:0] pos(input int k);
    int x, y, e;
    x = k % D;
    y = (k / D) % D;
    e = k / (D * D);
    return {16'(e), 16'(y), 16'(x)};
  endfunction

  function automatic logic [116:0] exp_vec();
    return {m_ph == 1, m_ph == 1, m_ph == 2, m_ww, m_err, m_data, m_idx};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_k = 0; m_ww = 0; m_err = 0; m_data = '0; m_idx = '0;
  endtask

  // Apply inputs for the next rising edge, advance the model, wait to the falling edge.
  task automatic drive(input bit st, input bit vld, input logic [63:0] d);
    bit acc;
    start = st; in_valid = vld; in_data = d;
    acc = (m_ph == 1) && vld;
`ifdef ACT_LOADER_CHECK_EN
    if ((vld && m_ph != 1) || (st && m_ph != 0)) m_err = 1;
`endif
    m_ww = acc;
    if (acc) begin
      m_data = d;
      m_idx  = pos(m_k);
      m_k++;
    end
    case (m_ph)
      0: if (st) begin m_ph = 1; m_k = 0; end
      1: if (acc && m_k == m_total) m_ph = 2;
      default: m_ph = 0;
    endcase
    @(negedge clk);
  endtask

  // Feed words until 'limit' accepted or the load ends; checks every cycle.
  task automatic run_words(input string name, input int vmode, input bit hold,
                           input int limit, output int writes);
    int cyc;
    bit v;
    logic [63:0] d;
    cyc = 0; writes = 0; first_idx = '1; seen26 = '1;
    while (m_ph == 1 && m_k < limit && cyc < 400) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = v ? $realtobits(real'(m_k + 1)) : {$urandom, $urandom};
      drive(hold, v, d);
      cyc++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h", name, cyc, obs, exp_vec());
      end
      if (obs_ww === 1'b1) begin
        if (writes == 0) first_idx = obs_idx;
        if (obs_data == $realtobits(26.0)) seen26 = obs_idx;
        writes++;
      end
    end
    if (cyc >= 400) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles want fewer than 400", name, cyc);
    end
  endtask

  task automatic test_reset(input string name);
    rst_n = 1'b0; start = 0; in_valid = 0; in_data = '0;
    model_reset();
    sel = 0; #1;
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL %s_dut1: got %h want %h", name, obs, exp_vec());
    end
    sel = 1; #1;
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL %s_dut2: got %h want %h", name, obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, '0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL %s_idle: got %h want %h", name, obs, exp_vec());
    end
  endtask

  task automatic test_single_map();
    int w;
    test_reset("pre_single");
    sel = 0; m_total = 25; #1;
    drive(1, 0, '0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL single_start: got %h want %h", obs, exp_vec());
    end
    run_words("single", 0, 0, 1000, w);
    n_checks++;
    if (!(obs_data === 64'h4039_0000_0000_0000 && obs_idx === {16'd0, 16'd4, 16'd4} &&
          obs[114] === 1'b1 && obs_ww === 1'b1)) begin
      n_fail++;
      $display("FAIL single_last: got data %h idx %h done %b want 4039000000000000 idx 000000040004 done 1",
               obs_data, obs_idx, obs[114]);
    end
    n_checks++;
    if (w != 25) begin
      n_fail++; $display("FAIL single_count: got %0d want 25", w);
    end
    drive(0, 0, {$urandom, $urandom});
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL single_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_two_maps();
    int w;
    test_reset("pre_two");
    sel = 1; m_total = 50; #1;
    drive(1, 0, '0);
    run_words("two_maps", 1, 0, 1000, w);
    n_checks++;
    if (w != 50) begin
      n_fail++; $display("FAIL two_count: got %0d want 50", w);
    end
    n_checks++;
    if (seen26 !== {16'd1, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL two_word26: got %h want 000100000000", seen26);
    end
    drive(0, 0, '0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL two_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_idle_valid();
    test_reset("pre_idle_valid");
    sel = 0; m_total = 25; #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, $realtobits(7.0));
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL idle_valid cycle %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    drive(0, 0, '0);
    n_checks++;
    if (obs_ww !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid_nowrite: got %b want 0", obs_ww);
    end
`ifdef ACT_LOADER_CHECK_EN
    n_checks++;
    if (err1 !== 1'b1) begin
      n_fail++; $display("FAIL idle_valid_err: got %b want 1", err1);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    int w;
    test_reset("pre_mid");
    sel = 0; m_total = 25; #1;
    drive(1, 0, '0);
    run_words("mid_first10", 0, 0, 10, w);
    #1;
    rst_n = 1'b0; start = 0; in_valid = 0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL mid_async_reset: got %h want %h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, '0);
    drive(1, 0, '0);
    run_words("mid_reload", 2, 0, 1000, w);
    n_checks++;
    if (w != 25 || first_idx !== 48'd0) begin
      n_fail++; $display("FAIL mid_reload: got %0d writes first %h want 25 writes first 0", w, first_idx);
    end
  endtask

  task automatic test_start_held();
    int w;
    test_reset("pre_held");
    sel = 1; m_total = 50; #1;
    drive(1, 0, '0);
    run_words("held", 2, 1, 1000, w);
    n_checks++;
    if (w != 50 || first_idx !== 48'd0) begin
      n_fail++; $display("FAIL held_count: got %0d writes first %h want 50 writes first 0", w, first_idx);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL held_tail %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    test_reset("pre_b2b");
    sel = 0; m_total = 25; #1;
    drive(1, 0, '0);
    run_words("b2b_first", 0, 0, 1000, w1);
    drive(0, 0, '0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_gap: got %h want %h", obs, exp_vec());
    end
    drive(1, 0, '0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_restart: got %h want %h", obs, exp_vec());
    end
    run_words("b2b_second", 0, 0, 1000, w2);
    n_checks++;
    if (w1 != 25 || w2 != 25 || first_idx !== 48'd0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d/%0d writes first %h want 25/25 first 0", w1, w2, first_idx);
    end
  endtask

  initial begin
    model_reset();
    m_total = 25;
    @(negedge clk);
    test_reset("reset");
    test_single_map();
    test_two_maps();
    test_idle_valid();
    test_reset_mid_load();
    test_start_held();
    test_back_to_back();
    test_reset("final_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
